vga_scan_engine: RTL and testbench

Parametrised successor to the board-level VGA scan path. It replaces the fixed 25 MHz scan plus the derived `DIV_CLK[16]` movement clock with a single-clock engine. The engine generates the pixel-enable strobe, horizontal/vertical counters, sync pulses, the `bright` window, line/frame strobes and a movement strobe, all as same-clock enables rather than derived clocks. It sits between the board clock and the game/block controller; downstream logic samples `hCount`/`vCount`/`bright` on `pix_en`.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_tick_div.sv | 33 +++
 rtl/vga_scan_engine.sv | 133 +++++++++++++
 tb/tb_vga_scan_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, total-length
// helpers and the sync polarity pair used by the scan engine.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_pol_t;

    // Active levels of the two syncs for the standard 640x480 mode.
    localparam sync_pol_t SYNC_POL_NEG = '{hsync: 1'b0, vsync: 1'b0};

    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Modulus-MOD counter with enable. tc flags the terminal count in the current
// cycle; tick is the same condition registered, so it is high for one cycle.
module vga_tick_div #(
    parameter int MOD = 4
) (
    input  logic ClkPort,
    input  logic Reset_n,
    input  logic en,
    output logic tc,
    output logic tick
);

    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tc;
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_engine.sv
// Single-clock VGA scan engine: pixel strobe, h/v counters, registered sync and
// visibility decode, line/frame strobes and a movement strobe.
module vga_scan_engine
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV       = DEF_CLK_DIV,
    parameter int   H_VISIBLE     = DEF_H_VISIBLE,
    parameter int   H_FP          = DEF_H_FP,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BP          = DEF_H_BP,
    parameter int   V_VISIBLE     = DEF_V_VISIBLE,
    parameter int   V_FP          = DEF_V_FP,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BP          = DEF_V_BP,
    parameter logic HSYNC_POL     = SYNC_POL_NEG.hsync,
    parameter logic VSYNC_POL     = SYNC_POL_NEG.vsync,
    parameter int   CNT_W         = 10,
    parameter int   MOVE_MODE     = 0,
    parameter int   MOVE_DIV_LOG2 = 17
) (
    input  logic             ClkPort,
    input  logic             Reset_n,
    input  logic             en,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             line_start,
    output logic             frame_start,
    output logic             move_tick
);

    localparam int H_TOTAL  = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOT  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_scan_engine: CLK_DIV must be at least 1");
    end
    if ((1 << CNT_W) < MAX_TOT) begin : g_bad_cnt_w
        $error("vga_scan_engine: CNT_W too narrow for the frame totals");
    end

    logic             pix_adv;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             nxt_bright;
    logic             nxt_hs_act;
    logic             nxt_vs_act;

    vga_tick_div #(
        .MOD (CLK_DIV)
    ) u_pix_div (
        .ClkPort (ClkPort),
        .Reset_n (Reset_n),
        .en      (en),
        .tc      (pix_adv),
        .tick    (pix_en)
    );

    // Decode is taken from the position the counters are about to present, so
    // the registered flags line up with hCount/vCount on the same edge.
    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (hCount == H_LAST) begin
            h_next = '0;
            v_next = (vCount == V_LAST) ? '0 : vCount + 1'b1;
        end else begin
            h_next = hCount + 1'b1;
        end
        nxt_bright = (int'(h_next) < H_VISIBLE) && (int'(v_next) < V_VISIBLE);
        nxt_hs_act = (int'(h_next) >= HS_START) && (int'(h_next) < HS_END);
        nxt_vs_act = (int'(v_next) >= VS_START) && (int'(v_next) < VS_END);
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            hCount      <= '0;
            vCount      <= '0;
            bright      <= 1'b0;
            hSync       <= ~HSYNC_POL;
            vSync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            bright      <= 1'b0;
            hSync       <= ~HSYNC_POL;
            vSync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_adv) begin
            hCount      <= h_next;
            vCount      <= v_next;
            bright      <= nxt_bright;
            hSync       <= nxt_hs_act ? HSYNC_POL : ~HSYNC_POL;
            vSync       <= nxt_vs_act ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end else begin
            // Between strobes the decode holds; after a re-enable it stays blank
            // until the first update.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    if (MOVE_MODE == 0) begin : g_move_div
        logic move_tc_unused;

        vga_tick_div #(
            .MOD (1 << MOVE_DIV_LOG2)
        ) u_move_div (
            .ClkPort (ClkPort),
            .Reset_n (Reset_n),
            .en      (1'b1),
            .tc      (move_tc_unused),
            .tick    (move_tick)
        );
    end else begin : g_move_frame
        assign move_tick = frame_start;
    end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: a default-timing instance (fast movement divider)
// and a miniature 15x8 instance with CLK_DIV=1, active-high hSync, frame-locked move.
module tb_vga_scan_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, en_a = 1'b0;
    logic       rst_b = 1'b0, en_b = 1'b0;
    logic       a_pix, a_bright, a_hs, a_vs, a_ls, a_fs, a_move;
    logic       b_pix, b_bright, b_hs, b_vs, b_ls, b_fs, b_move;
    logic [9:0] a_h, a_v, b_h, b_v;

    int vec_cnt = 0;
    int err_cnt = 0;

    vga_scan_engine #(
        .MOVE_DIV_LOG2 (4)
    ) u_a (
        .ClkPort     (clk),
        .Reset_n     (rst_a),
        .en          (en_a),
        .pix_en      (a_pix),
        .hCount      (a_h),
        .vCount      (a_v),
        .bright      (a_bright),
        .hSync       (a_hs),
        .vSync       (a_vs),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .move_tick   (a_move)
    );

    vga_scan_engine #(
        .CLK_DIV   (1),
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (2),
        .V_VISIBLE (4),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .HSYNC_POL (1'b1),
        .MOVE_MODE (1)
    ) u_b (
        .ClkPort     (clk),
        .Reset_n     (rst_b),
        .en          (en_b),
        .pix_en      (b_pix),
        .hCount      (b_h),
        .vCount      (b_v),
        .bright      (b_bright),
        .hSync       (b_hs),
        .vSync       (b_vs),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .move_tick   (b_move)
    );

    // Movement strobe monitor for instance A: every gap must be 16 cycles.
    int cyc = 0;
    int last_move = -1;
    int move_cnt = 0;
    int move_bad = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst_a) begin
            last_move = -1;
        end else if (a_move) begin
            if (last_move >= 0 && (cyc - last_move) != 16) move_bad++;
            last_move = cyc;
            move_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_a(input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_pix && a_h == 10'(h) && a_v == 10'(v)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b(input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b_pix && b_h == 10'(h) && b_v == 10'(v)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // exp = {bright, hSync, vSync, line_start, frame_start} after the update into (h,v)
    typedef struct {
        int         h;
        int         v;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[16];

    initial begin
        bit ok;
        int n, hs_cnt, hs_first, hs_last, br_cnt, bad;
        int f_br, f_ls, f_fs, f_hs, f_vs, f_pl, f_mt;

        vecs[0]  = '{1, 0, 5'b10100};
        vecs[1]  = '{7, 0, 5'b10100};
        vecs[2]  = '{8, 0, 5'b00100};
        vecs[3]  = '{10, 0, 5'b01100};
        vecs[4]  = '{12, 0, 5'b01100};
        vecs[5]  = '{13, 0, 5'b00100};
        vecs[6]  = '{14, 0, 5'b00100};
        vecs[7]  = '{0, 1, 5'b10110};
        vecs[8]  = '{7, 3, 5'b10100};
        vecs[9]  = '{0, 4, 5'b00110};
        vecs[10] = '{0, 5, 5'b00010};
        vecs[11] = '{9, 6, 5'b00000};
        vecs[12] = '{0, 7, 5'b00110};
        vecs[13] = '{14, 7, 5'b00100};
        vecs[14] = '{0, 0, 5'b10111};
        vecs[15] = '{1, 0, 5'b10100};

        // Reset values
        repeat (3) @(negedge clk);
        check("a_reset", {a_h, a_v, a_pix, a_bright, a_hs, a_vs, a_ls, a_fs, a_move},
              {10'd0, 10'd0, 7'b0011000});
        check("b_reset", {b_h, b_v, b_pix, b_bright, b_hs, b_vs, b_ls, b_fs, b_move},
              {10'd0, 10'd0, 7'b0001000});

        // A: first strobe on the 4th edge, then every 4 edges
        rst_a = 1'b1;
        en_a  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("a_startup_edge%0d", k), {a_pix, a_bright, a_h, a_v},
                  {(k % 4 == 0), (k >= 4), 10'(k / 4), 10'd0});
        end

        // A: disable at (300,0) for 50 cycles
        wait_a(300, 0, 2000, ok);
        check("a_reach_300_0", ok, 1'b1);
        en_a = 1'b0;
        @(negedge clk);
        check("a_disable_blank", {a_h, a_v, a_pix, a_bright, a_hs, a_vs, a_ls, a_fs},
              {10'd300, 10'd0, 6'b001100});
        bad = 0;
        n = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (a_h != 10'd300 || a_pix || a_bright || !a_hs) bad++;
            if (a_move) n++;
        end
        check("a_disable_hold", bad, 0);
        check("a_move_while_disabled", (n >= 3 && n <= 4), 1'b1);
        en_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("a_reenable_edge%0d", k), {a_pix, a_bright, a_h}, {2'b00, 10'd300});
        end
        @(negedge clk);
        check("a_reenable_edge4", {a_pix, a_bright, a_h, a_v}, {2'b11, 10'd301, 10'd0});

        // A: rest of line 0, hSync window and visible span, wrap to (0,1)
        hs_cnt = 0; hs_first = -1; hs_last = -1; br_cnt = 0; ok = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            if (a_pix) begin
                if (a_h == 10'd0 && a_v == 10'd1) begin
                    ok = 1'b1;
                    break;
                end
                if (!a_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(a_h);
                    hs_last = int'(a_h);
                end
                if (a_bright) br_cnt++;
            end
        end
        check("a_line_wrap_found", ok, 1'b1);
        check("a_line_wrap_flags", {a_bright, a_hs, a_vs, a_ls, a_fs}, 5'b11110);
        check("a_hsync_width", hs_cnt, 96);
        check("a_hsync_first", hs_first, 656);
        check("a_hsync_last", hs_last, 751);
        check("a_bright_302_639", br_cnt, 338);

        // A: asynchronous reset between clock edges
        #2 rst_a = 1'b0;
        #1;
        check("a_async_reset", {a_h, a_v, a_pix, a_bright, a_hs, a_vs, a_ls, a_fs, a_move},
              {10'd0, 10'd0, 7'b0011000});
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (40) @(negedge clk);
        check("a_move_period", move_bad, 0);
        check("a_move_seen", move_cnt > 100, 1'b1);

        // B: table walk through a whole miniature frame
        rst_b = 1'b1;
        en_b  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_b(vecs[i].h, vecs[i].v, 100, ok);
            check($sformatf("b_vec%0d_%0d_%0d", i, vecs[i].h, vecs[i].v),
                  {ok, b_bright, b_hs, b_vs, b_ls, b_fs}, {1'b1, vecs[i].exp});
        end

        // B: one full frame of 120 strobes starting at the (0,0) update
        wait_b(0, 0, 200, ok);
        check("b_frame_found", ok, 1'b1);
        f_br = 0; f_ls = 0; f_fs = 0; f_hs = 0; f_vs = 0; f_pl = 0; f_mt = 0;
        for (int i = 0; i < 120; i++) begin
            if (b_bright) f_br++;
            if (b_ls) f_ls++;
            if (b_fs) f_fs++;
            if (b_hs) f_hs++;
            if (!b_vs) f_vs++;
            if (!b_pix) f_pl++;
            if (b_move !== b_fs) f_mt++;
            if (i < 119) @(negedge clk);
        end
        check("b_frame_bright", f_br, 32);
        check("b_frame_line_start", f_ls, 8);
        check("b_frame_frame_start", f_fs, 1);
        check("b_frame_hsync_active", f_hs, 24);
        check("b_frame_vsync_active", f_vs, 30);
        check("b_pix_en_low", f_pl, 0);
        check("b_move_vs_frame", f_mt, 0);
        @(negedge clk);
        check("b_after_frame", {b_h, b_v, b_pix}, {10'd0, 10'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
